// File: rtl/ecc_pt_regfile.sv
// Point register file for an ECC datapath: DEPTH (x,y) entries loadable from the core, the
// generator constant or an external port, with a word-serial readout stream.
module ecc_pt_regfile #(
  parameter int unsigned    W     = 256,
  parameter int unsigned    DEPTH = 4,
  parameter int unsigned    BW    = 32,
  parameter logic [W-1:0]   GX    =
    256'h62417dda94dd5719e7edccaddd889441d6ea57f17fb6d805e79cc35062a450f0,
  parameter logic [W-1:0]   GY    =
    256'h15c7fc62962176154ba21a237487cc962d2ae390e867917377c94d5f3a55582a
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       clr,
  input  logic                       op_valid,
  output logic                       op_ready,
  input  logic [2:0]                 op,
  input  logic [$clog2(DEPTH)-1:0]   idx,
  input  logic [$clog2(DEPTH)-1:0]   idx_b,
  input  logic [W-1:0]               ecp_xp,
  input  logic [W-1:0]               ecp_yp,
  input  logic [W-1:0]               x,
  input  logic [W-1:0]               y,
  input  logic [$clog2(DEPTH)-1:0]   rd_idx,
  output logic [W-1:0]               sel_x,
  output logic [W-1:0]               sel_y,
  output logic [DEPTH-1:0]           ent_valid,
  output logic [BW-1:0]              dout,
  output logic                       dout_valid,
  output logic                       dout_last
);

  localparam int unsigned IW = $clog2(DEPTH);
  localparam int unsigned NW = 2 * W / BW;
  localparam int unsigned CW = $clog2(NW);

  localparam logic [2:0] OpLdCore = 3'd0;
  localparam logic [2:0] OpLdGen  = 3'd1;
  localparam logic [2:0] OpLdExt  = 3'd2;
  localparam logic [2:0] OpClr    = 3'd3;
  localparam logic [2:0] OpSwap   = 3'd4;
  localparam logic [2:0] OpRdout  = 3'd5;
  localparam logic [2:0] OpClrAll = 3'd6;
  localparam logic [2:0] OpNop    = 3'd7;

  typedef enum logic {StIdle, StStream} state_e;

  state_e           state_q;
  logic [W-1:0]     ent_x_q [DEPTH];
  logic [W-1:0]     ent_y_q [DEPTH];
  logic [W-1:0]     ent_x_d [DEPTH];
  logic [W-1:0]     ent_y_d [DEPTH];
  logic [DEPTH-1:0] vld_q, vld_d;
  logic [2*W-1:0]   sh_q;
  logic [CW-1:0]    cnt_q;
  logic [BW-1:0]    dout_q;
  logic             dout_valid_q, dout_last_q;
  logic             accept;

  // Indices are clog2-wide, so non-power-of-two depths can address missing entries.
  function automatic logic in_rng(input logic [IW-1:0] i);
    return 32'(i) < DEPTH;
  endfunction

  assign op_ready   = (state_q == StIdle) && !clr;
  assign accept     = op_valid && op_ready;
  assign ent_valid  = vld_q;
  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
  assign dout_last  = dout_last_q;

  always_comb begin
    sel_x = '0;
    sel_y = '0;
    if (in_rng(rd_idx)) begin
      sel_x = ent_x_q[rd_idx];
      sel_y = ent_y_q[rd_idx];
    end
  end

  always_comb begin
    ent_x_d = ent_x_q;
    ent_y_d = ent_y_q;
    vld_d   = vld_q;
    if (clr) begin
      ent_x_d = '{default: '0};
      ent_y_d = '{default: '0};
      vld_d   = '0;
    end else if (accept) begin
      unique case (op)
        OpLdCore, OpLdGen, OpLdExt: begin
          if (in_rng(idx)) begin
            ent_x_d[idx] = (op == OpLdCore) ? ecp_xp : (op == OpLdGen) ? GX : x;
            ent_y_d[idx] = (op == OpLdCore) ? ecp_yp : (op == OpLdGen) ? GY : y;
            vld_d[idx]   = 1'b1;
          end
        end
        OpClr: begin
          if (in_rng(idx)) begin
            ent_x_d[idx] = '0;
            ent_y_d[idx] = '0;
            vld_d[idx]   = 1'b0;
          end
        end
        OpSwap: begin
          // idx == idx_b falls out naturally as a self-copy.
          if (in_rng(idx) && in_rng(idx_b)) begin
            ent_x_d[idx]   = ent_x_q[idx_b];
            ent_y_d[idx]   = ent_y_q[idx_b];
            vld_d[idx]     = vld_q[idx_b];
            ent_x_d[idx_b] = ent_x_q[idx];
            ent_y_d[idx_b] = ent_y_q[idx];
            vld_d[idx_b]   = vld_q[idx];
          end
        end
        OpClrAll: begin
          ent_x_d = '{default: '0};
          ent_y_d = '{default: '0};
          vld_d   = '0;
        end
        OpRdout, OpNop: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ent_x_q <= '{default: '0};
      ent_y_q <= '{default: '0};
      vld_q   <= '0;
    end else begin
      ent_x_q <= ent_x_d;
      ent_y_q <= ent_y_d;
      vld_q   <= vld_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      sh_q         <= '0;
      cnt_q        <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      dout_last_q  <= 1'b0;
    end else if (clr) begin
      state_q      <= StIdle;
      sh_q         <= '0;
      cnt_q        <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      dout_last_q  <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (accept && op == OpRdout && in_rng(idx)) begin
            // Word 0 goes out directly; the shifter holds the remaining words.
            state_q      <= StStream;
            sh_q         <= {ent_y_q[idx], ent_x_q[idx]} >> BW;
            dout_q       <= ent_x_q[idx][BW-1:0];
            dout_valid_q <= 1'b1;
            dout_last_q  <= 1'b0;
            cnt_q        <= '0;
          end
        end
        StStream: begin
          if (cnt_q == CW'(NW - 1)) begin
            state_q      <= StIdle;
            cnt_q        <= '0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            dout_last_q  <= 1'b0;
          end else begin
            cnt_q       <= cnt_q + 1'b1;
            dout_q      <= sh_q[BW-1:0];
            sh_q        <= sh_q >> BW;
            dout_last_q <= (cnt_q == CW'(NW - 2));
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ecc_pt_regfile.sv
// Directed bench for ecc_pt_regfile: point ops checked directly, readout words checked by a
// scoreboard queue drained by a negedge monitor. A DEPTH=3 copy shares the stimulus.
module tb_ecc_pt_regfile;

  localparam logic [255:0] GX =
    256'h62417dda94dd5719e7edccaddd889441d6ea57f17fb6d805e79cc35062a450f0;
  localparam logic [255:0] GY =
    256'h15c7fc62962176154ba21a237487cc962d2ae390e867917377c94d5f3a55582a;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         clr, op_valid;
  logic [2:0]   op;
  logic [1:0]   idx, idx_b, rd_idx;
  logic [255:0] ecp_xp, ecp_yp, x, y;

  logic         op_ready, dout_valid, dout_last;
  logic [255:0] sel_x, sel_y;
  logic [3:0]   ent_valid;
  logic [31:0]  dout;

  logic         op_ready3, dout_valid3, dout_last3;
  logic [255:0] sel_x3, sel_y3;
  logic [2:0]   ent_valid3;
  logic [31:0]  dout3;

  int           n_cmp = 0;
  int           n_bad = 0;
  int           n;
  logic [32:0]  exp_q[$];
  logic [32:0]  e;

  ecc_pt_regfile u_dut (
    .clk(clk), .rst_n(rst_n), .clr(clr), .op_valid(op_valid), .op_ready(op_ready), .op(op),
    .idx(idx), .idx_b(idx_b), .ecp_xp(ecp_xp), .ecp_yp(ecp_yp), .x(x), .y(y),
    .rd_idx(rd_idx), .sel_x(sel_x), .sel_y(sel_y), .ent_valid(ent_valid), .dout(dout),
    .dout_valid(dout_valid), .dout_last(dout_last)
  );

  ecc_pt_regfile #(.DEPTH(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .clr(clr), .op_valid(op_valid), .op_ready(op_ready3), .op(op),
    .idx(idx), .idx_b(idx_b), .ecp_xp(ecp_xp), .ecp_yp(ecp_yp), .x(x), .y(y),
    .rd_idx(rd_idx), .sel_x(sel_x3), .sel_y(sel_y3), .ent_valid(ent_valid3), .dout(dout3),
    .dout_valid(dout_valid3), .dout_last(dout_last3)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Monitor: every valid word must match the head of the expected queue.
  always @(negedge clk) begin
    if (dout_valid === 1'b1) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL dout_extra: got word %0h with none expected", dout);
      end else begin
        e = exp_q.pop_front();
        if ({dout_last, dout} !== e) begin
          n_bad++;
          $display("FAIL dout_word: got last=%0b data=%0h want last=%0b data=%0h",
                   dout_last, dout, e[32], e[31:0]);
        end
      end
    end else if (rst_n === 1'b1) begin
      n_cmp++;
      if (dout !== 32'd0 || dout_last !== 1'b0) begin
        n_bad++;
        $display("FAIL dout_idle: got dout=%0h last=%0b want 0", dout, dout_last);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [2:0] o, input logic [1:0] i, input logic [1:0] ib);
    op = o;
    idx = i;
    idx_b = ib;
    op_valid = 1'b1;
    step();
    op_valid = 1'b0;
    op = 3'd7;
  endtask

  task automatic push_stream(input logic [511:0] v);
    for (int k = 0; k < 16; k++) exp_q.push_back({k == 15, v[k*32 +: 32]});
  endtask

  task automatic wait_idle(output int cyc);
    cyc = 0;
    while (op_ready !== 1'b1 && cyc < 40) begin
      cyc++;
      step();
    end
  endtask

  initial begin
    clr = 1'b0; op_valid = 1'b0; op = 3'd7; idx = '0; idx_b = '0; rd_idx = '0;
    ecp_xp = '0; ecp_yp = '0; x = '0; y = '0;
    #2;
    chk("reset_ent_valid", 512'(ent_valid), 512'd0);
    chk("reset_dout_valid", 512'(dout_valid), 512'd0);
    chk("reset_op_ready", 512'(op_ready), 512'd1);
    #20 rst_n = 1'b1;
    step();
    chk("post_reset_ready", 512'(op_ready), 512'd1);

    issue(3'd1, 2'd2, 2'd0);
    rd_idx = 2'd2; #1;
    chk("ld_gen_xy", {sel_x, sel_y}, {GX, GY});
    chk("ld_gen_valid", 512'(ent_valid), 512'(4'b0100));
    chk("ld_gen_valid_d3", 512'(ent_valid3), 512'(3'b100));

    issue(3'd3, 2'd2, 2'd0);
    chk("clr_valid", 512'(ent_valid), 512'd0);
    chk("clr_xy", {sel_x, sel_y}, 512'd0);

    x = 256'd1; y = 256'd2;
    issue(3'd2, 2'd0, 2'd0);
    issue(3'd4, 2'd0, 2'd3);
    rd_idx = 2'd3; #1;
    chk("swap_e3", {sel_x, sel_y}, {256'd1, 256'd2});
    rd_idx = 2'd0; #1;
    chk("swap_e0", {sel_x, sel_y}, 512'd0);
    chk("swap_valid", 512'(ent_valid), 512'(4'b1000));
    chk("swap_oob_d3", 512'(ent_valid3), 512'(3'b001));

    issue(3'd4, 2'd3, 2'd3);
    rd_idx = 2'd3; #1;
    chk("swap_self_xy", {sel_x, sel_y}, {256'd1, 256'd2});
    chk("swap_self_valid", 512'(ent_valid), 512'(4'b1000));

    push_stream({256'd2, 256'd1});
    issue(3'd5, 2'd3, 2'd0);
    chk("rdout_oob_ready_d3", 512'(op_ready3), 512'd1);
    wait_idle(n);
    chk("rdout_busy_cycles", 512'(n), 512'd16);
    chk("rdout_all_words", 512'(exp_q.size()), 512'd0);

    ecp_xp = 256'd5; ecp_yp = 256'd6;
    issue(3'd0, 2'd3, 2'd0);
    chk("ldcore_oob_valid_d3", 512'(ent_valid3), 512'(3'b001));
    chk("ldcore_oob_ready_d3", 512'(op_ready3), 512'd1);
    chk("ldcore_oob_sel_d3", {sel_x3, sel_y3}, 512'd0);
    chk("ldcore_e3", {sel_x, sel_y}, {256'd5, 256'd6});

    issue(3'd1, 2'd1, 2'd0);
    push_stream({GY, GX});
    issue(3'd5, 2'd1, 2'd0);
    repeat (5) step();
    while (exp_q.size() > 1) void'(exp_q.pop_back());
    clr = 1'b1;
    op = 3'd1; idx = 2'd0; op_valid = 1'b1;
    #1;
    chk("clr_ready_low", 512'(op_ready), 512'd0);
    step();
    op_valid = 1'b0; op = 3'd7;
    rd_idx = 2'd1; #1;
    chk("abort_dout_valid", 512'(dout_valid), 512'd0);
    chk("abort_dout", 512'(dout), 512'd0);
    chk("abort_ent_valid", 512'(ent_valid), 512'd0);
    chk("abort_sel", {sel_x, sel_y}, 512'd0);
    clr = 1'b0; #1;
    chk("abort_ready", 512'(op_ready), 512'd1);
    chk("abort_words", 512'(exp_q.size()), 512'd0);

    x = 256'hdeadbeef_00000000_0000cafe; y = 256'h1234_5678;
    issue(3'd2, 2'd0, 2'd0);
    push_stream({y, x});
    issue(3'd5, 2'd0, 2'd0);
    step();
    step();
    #2;
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    chk("rst_dout_valid", 512'(dout_valid), 512'd0);
    chk("rst_dout", 512'({dout_last, dout}), 512'd0);
    chk("rst_ent_valid", 512'(ent_valid), 512'd0);
    #3 rst_n = 1'b1;
    step();
    chk("rst_release_ready", 512'(op_ready), 512'd1);
    chk("rst_release_idle", 512'(dout_valid), 512'd0);

    step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ecc_pt_regfile.md
ECC_PT_REGFILE -- requirements
Module: ecc_pt_regfile

Interface
REQ-001 Parameter W, default 256: coordinate width in bits; SHALL be a multiple of BW.
REQ-002 Parameter DEPTH, default 4: number of point entries, range 2..16.
REQ-003 Parameter BW, default 32: readout word width in bits.
REQ-004 Parameter GX, default 256'h62417dda94dd5719e7edccaddd889441d6ea57f17fb6d805e79cc35062a450f0: generator x constant.
REQ-005 Parameter GY, default 256'h15c7fc62962176154ba21a237487cc962d2ae390e867917377c94d5f3a55582a: generator y constant.
REQ-006 clk  in  1  single clock; all state updates on its rising edge.
REQ-007 rst_n  in  1  asynchronous, active-low reset.
REQ-008 clr  in  1  synchronous clear-all; highest priority.
REQ-009 op_valid  in  1  operation request.
REQ-010 op_ready  out  1  high when an operation can be accepted.
REQ-011 op  in  3  opcode: 0 LD_CORE, 1 LD_GEN, 2 LD_EXT, 3 CLR, 4 SWAP, 5 RDOUT, 6 CLR_ALL, 7 NOP.
REQ-012 idx, idx_b  in  clog2(DEPTH) each  target entry and second SWAP entry.
REQ-013 ecp_xp, ecp_yp  in  W each  core result point.
REQ-014 x, y  in  W each  external point.
REQ-015 rd_idx  in  clog2(DEPTH)  combinational read select.
REQ-016 sel_x, sel_y  out  W each  entry[rd_idx] coordinates, combinational; 0 if rd_idx >= DEPTH.
REQ-017 ent_valid  out  DEPTH  per-entry loaded flag.
REQ-018 dout  out  BW  readout word; dout_valid  out  1; dout_last  out  1.

Function
REQ-019 An op SHALL be accepted on a rising edge with op_valid && op_ready; its effect SHALL be visible the following cycle.
REQ-020 op_ready SHALL equal (state == IDLE) && !clr.
REQ-021 LD_CORE/LD_GEN/LD_EXT SHALL write {ecp_xp,ecp_yp} / {GX,GY} / {x,y} to entry[idx] and set ent_valid[idx].
REQ-022 CLR SHALL zero entry[idx] and clear ent_valid[idx].
REQ-023 SWAP SHALL exchange entry[idx] and entry[idx_b], valid flags included, in one cycle; idx == idx_b SHALL be a no-op.
REQ-024 Any op whose idx or idx_b is >= DEPTH SHALL be accepted and have no effect.
REQ-025 CLR_ALL SHALL zero all entries and clear all ent_valid bits; NOP SHALL have no effect.
REQ-026 RDOUT SHALL snapshot entry[idx] into a 2W-bit shift register and move the state machine from IDLE to STREAM.
REQ-027 In STREAM, dout_valid SHALL be high for exactly 2*W/BW consecutive cycles, starting the cycle after acceptance.
REQ-028 Word order SHALL be x least-significant word first through x MS word, then y LS word to y MS word.
REQ-029 dout_last SHALL be high only with the final word; the state machine SHALL return to IDLE the next cycle, so op_ready rises then.
REQ-030 A word counter of clog2(2*W/BW) bits SHALL track progress; it SHALL NOT wrap into a second pass.
REQ-031 dout SHALL be 0 whenever dout_valid is low.
REQ-032 clr SHALL zero all entries, ent_valid, dout, dout_valid, dout_last and the counter, and force IDLE, including aborting a STREAM mid-transfer; a simultaneous op SHALL be ignored.
REQ-033 Entries SHALL NOT change during STREAM except via clr.

Reset
REQ-034 While rst_n is low, all entries, ent_valid, counter, dout, dout_valid and dout_last SHALL be 0 and the state SHALL be IDLE, without waiting for a clock edge.
REQ-035 After rst_n deasserts, op_ready SHALL be 1 on the first cycle in which clr is low.

Verification
REQ-036 Reset, then LD_GEN idx=2 -> next cycle sel_x=GX, sel_y=GY at rd_idx=2; ent_valid=4'b0100.
REQ-037 LD_EXT idx=0 (x=1, y=2), then SWAP idx=0, idx_b=3 -> entry3={1,2}, entry0=0, ent_valid=4'b1000.
REQ-038 RDOUT of entry with x=1, y=2 -> 16 dout_valid cycles; word0=1, word8=2, all other words 0; dout_last on word15; op_ready low for 16 cycles.
REQ-039 clr asserted at word 5 of RDOUT -> next cycle dout_valid=0, all entries 0, op_ready=1 once clr drops.
REQ-040 DEPTH=3 build: LD_CORE idx=3 -> no entry changes, op_ready stays 1.
REQ-041 rst_n pulled low mid-STREAM between clock edges -> outputs 0 immediately, and state is IDLE after release.
